// File: rtl/ar_arbiter_pkg.sv
// Shared AXI read-address arbitration types: grant encoding seen by the AR mux,
// arbiter state and round-robin pointer, plus the winner-selection rule.
package ar_arbiter_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_M0   = 2'b01,
    GNT_M1   = 2'b10
  } ar_gnt_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_M0 = 2'd1,
    ST_GNT_M1 = 2'd2
  } ar_state_e;

  typedef enum logic {
    PTR_M0 = 1'b0,
    PTR_M1 = 1'b1
  } ar_ptr_e;

  // Contention goes to the pointed-at master only in round-robin mode.
  function automatic ar_state_e ar_pick(input logic v0, input logic v1,
                                        input ar_ptr_e ptr, input logic rr_en);
    ar_state_e w;
    w = ST_IDLE;
    if (v0 && v1)  w = (rr_en && ptr == PTR_M1) ? ST_GNT_M1 : ST_GNT_M0;
    else if (v0)   w = ST_GNT_M0;
    else if (v1)   w = ST_GNT_M1;
    return w;
  endfunction

  function automatic ar_gnt_e ar_to_gnt(input ar_state_e s);
    ar_gnt_e g;
    g = GNT_NONE;
    case (s)
      ST_GNT_M0: g = GNT_M0;
      ST_GNT_M1: g = GNT_M1;
      default:   g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    count <= '0;
    else if (clr)                  count <= '0;
    else if (inc && count != '1)   count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/ar_arbiter.sv
// Two-master AR-channel arbiter: holds a grant until handshake, then re-arbitrates
// with a rotated pointer; routes ARREADY to the owner and counts handshakes.
module ar_arbiter
  import ar_arbiter_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter bit RR_EN = 1'b1
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             ARVALID_M0,
  input  logic             ARVALID_M1,
  input  logic             ARREADY,
  output logic [1:0]       gnt,
  output logic             ARREADY_M0,
  output logic             ARREADY_M1,
  output logic             busy,
  output logic [CNT_W-1:0] hs_cnt_m0,
  output logic [CNT_W-1:0] hs_cnt_m1
);

  ar_state_e              state, state_nxt;
  ar_gnt_e                gnt_q;
  ar_ptr_e                ptr, ptr_nxt;
  logic                   busy_q;
  logic [NUM_MASTERS-1:0] hs;

  assign hs[0] = (state == ST_GNT_M0) & ARVALID_M0 & ARREADY;
  assign hs[1] = (state == ST_GNT_M1) & ARVALID_M1 & ARREADY;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      ST_IDLE: state_nxt = ar_pick(ARVALID_M0, ARVALID_M1, ptr, RR_EN);
      ST_GNT_M0: if (hs[0]) begin
        ptr_nxt   = PTR_M1;
        state_nxt = ar_pick(ARVALID_M0, ARVALID_M1, PTR_M1, RR_EN);
      end
      ST_GNT_M1: if (hs[1]) begin
        ptr_nxt   = PTR_M0;
        state_nxt = ar_pick(ARVALID_M0, ARVALID_M1, PTR_M0, RR_EN);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // gnt and busy are registered from the next state so the mux sees clean flops.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state  <= ST_IDLE;
      gnt_q  <= GNT_NONE;
      busy_q <= 1'b0;
      ptr    <= PTR_M0;
    end else begin
      state  <= state_nxt;
      gnt_q  <= ar_to_gnt(state_nxt);
      busy_q <= (state_nxt != ST_IDLE);
      ptr    <= ptr_nxt;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign ARREADY_M0 = ARREADY & gnt_q[0];
  assign ARREADY_M1 = ARREADY & gnt_q[1];

  sat_counter #(.WIDTH(CNT_W)) u_cnt_m0 (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .inc   (hs[0]),
    .clr   (1'b0),
    .count (hs_cnt_m0)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cnt_m1 (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .inc   (hs[1]),
    .clr   (1'b0),
    .count (hs_cnt_m1)
  );

endmodule

// File: tb/tb_ar_arbiter.sv
// Bench for ar_arbiter: three configurations share one stimulus stream and are
// compared every cycle against an owner/pointer/count model, plus literal pins.
module tb_ar_arbiter;

  logic ACLK = 1'b0;
  logic ARESETn, ARVALID_M0, ARVALID_M1, ARREADY;

  logic [1:0]  gnt_o [3];
  logic        busy_o[3];
  logic        r0_o  [3];
  logic        r1_o  [3];
  logic [15:0] c0_a, c1_a, c0_b, c1_b;
  logic [1:0]  c0_c, c1_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ACLK = ~ACLK;

  // u0: round-robin, u1: fixed priority, u2: fixed priority with 2-bit counters
  ar_arbiter #(.CNT_W(16), .RR_EN(1'b1)) u0 (
    .ACLK(ACLK), .ARESETn(ARESETn), .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1),
    .ARREADY(ARREADY), .gnt(gnt_o[0]), .ARREADY_M0(r0_o[0]), .ARREADY_M1(r1_o[0]),
    .busy(busy_o[0]), .hs_cnt_m0(c0_a), .hs_cnt_m1(c1_a));

  ar_arbiter #(.CNT_W(16), .RR_EN(1'b0)) u1 (
    .ACLK(ACLK), .ARESETn(ARESETn), .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1),
    .ARREADY(ARREADY), .gnt(gnt_o[1]), .ARREADY_M0(r0_o[1]), .ARREADY_M1(r1_o[1]),
    .busy(busy_o[1]), .hs_cnt_m0(c0_b), .hs_cnt_m1(c1_b));

  ar_arbiter #(.CNT_W(2), .RR_EN(1'b0)) u2 (
    .ACLK(ACLK), .ARESETn(ARESETn), .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1),
    .ARREADY(ARREADY), .gnt(gnt_o[2]), .ARREADY_M0(r0_o[2]), .ARREADY_M1(r1_o[2]),
    .busy(busy_o[2]), .hs_cnt_m0(c0_c), .hs_cnt_m1(c1_c));

  function automatic logic [31:0] cnt0(input int i);
    return (i == 0) ? 32'(c0_a) : (i == 1) ? 32'(c0_b) : 32'(c0_c);
  endfunction

  function automatic logic [31:0] cnt1(input int i);
    return (i == 0) ? 32'(c1_a) : (i == 1) ? 32'(c1_b) : 32'(c1_c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner is -1 (none), 0 or 1; pointer names the master favoured on contention.
  int m_rr [3] = '{1, 0, 0};
  int m_max[3] = '{65535, 65535, 3};
  int m_own[3] = '{-1, -1, -1};
  int m_ptr[3] = '{0, 0, 0};
  int m_c0 [3] = '{0, 0, 0};
  int m_c1 [3] = '{0, 0, 0};

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < 3; i++) begin
        m_own[i] <= -1; m_ptr[i] <= 0; m_c0[i] <= 0; m_c1[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int o, p, w;
        bit hs;
        o  = m_own[i];
        hs = (o == 0 && ARVALID_M0 && ARREADY) || (o == 1 && ARVALID_M1 && ARREADY);
        if (o == -1 || hs) begin
          p = hs ? 1 - o : m_ptr[i];
          if (ARVALID_M0 && ARVALID_M1) w = (m_rr[i] != 0) ? p : 0;
          else if (ARVALID_M0)          w = 0;
          else if (ARVALID_M1)          w = 1;
          else                          w = -1;
          m_own[i] <= w;
          m_ptr[i] <= p;
        end
        if (hs && o == 0 && m_c0[i] < m_max[i]) m_c0[i] <= m_c0[i] + 1;
        if (hs && o == 1 && m_c1[i] < m_max[i]) m_c1[i] <= m_c1[i] + 1;
      end
    end
  end

  always @(negedge ACLK) begin
    for (int i = 0; i < 3; i++) begin
      int eg;
      eg = (m_own[i] == 0) ? 1 : (m_own[i] == 1) ? 2 : 0;
      check($sformatf("u%0d_gnt", i),  32'(gnt_o[i]), eg);
      check($sformatf("u%0d_busy", i), 32'(busy_o[i]), (m_own[i] != -1) ? 1 : 0);
      check($sformatf("u%0d_rdy0", i), 32'(r0_o[i]), (ARREADY && m_own[i] == 0) ? 1 : 0);
      check($sformatf("u%0d_rdy1", i), 32'(r1_o[i]), (ARREADY && m_own[i] == 1) ? 1 : 0);
      check($sformatf("u%0d_cnt0", i), cnt0(i), m_c0[i]);
      check($sformatf("u%0d_cnt1", i), cnt1(i), m_c1[i]);
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask

  initial begin
    ARESETn = 1'b0; ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0; ARREADY = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_gnt_u%0d", i), 32'(gnt_o[i]), 0);
      check($sformatf("rst_busy_u%0d", i), 32'(busy_o[i]), 0);
    end

    // Ready with no grant must be ignored.
    ARESETn = 1'b1;
    ARREADY = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("idle_rdy_gnt_u%0d", i), 32'(gnt_o[i]), 0);
      check($sformatf("idle_rdy_cnt_u%0d", i), cnt0(i) + cnt1(i), 0);
      check($sformatf("idle_rdy_r0_u%0d", i), 32'(r0_o[i]), 0);
    end
    ARREADY = 1'b0;

    // Single requester M1, handshake in the third granted cycle.
    ARVALID_M1 = 1'b1;
    tick();
    check("m1_gc1_gnt", 32'(gnt_o[0]), 2);
    check("m1_gc1_rdy1", 32'(r1_o[0]), 0);
    tick();
    check("m1_gc2_gnt", 32'(gnt_o[1]), 2);
    tick();
    ARREADY = 1'b1;
    #1;
    check("m1_gc3_rdy1", 32'(r1_o[0]), 1);
    check("m1_gc3_rdy0", 32'(r0_o[0]), 0);
    tick();
    ARVALID_M1 = 1'b0; ARREADY = 1'b0;
    check("m1_cnt_u0", cnt1(0), 1);
    check("m1_cnt_u2", cnt1(2), 1);
    check("m1_regrant_gnt", 32'(gnt_o[0]), 2);

    // M0 granted: pulsed ready never leaks to M1; grant held with valid dropped.
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1; ARVALID_M0 = 1'b1;
    tick();
    check("iso_gnt", 32'(gnt_o[0]), 1);
    ARREADY = 1'b1;
    #1;
    check("iso_rdy0", 32'(r0_o[0]), 1);
    check("iso_rdy1", 32'(r1_o[0]), 0);
    tick();
    ARREADY = 1'b0; ARVALID_M0 = 1'b0;
    check("iso_cnt0", cnt0(0), 1);
    check("iso_cnt1", cnt1(0), 0);
    repeat (2) tick();
    check("iso_hold_gnt", 32'(gnt_o[0]), 1);

    // Asynchronous reset in the middle of a M1 grant.
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1; ARVALID_M1 = 1'b1;
    tick();
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    check("pre_rst_gnt", 32'(gnt_o[0]), 2);
    check("pre_rst_cnt1", cnt1(0), 1);
    #3;
    ARESETn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async_rst_gnt_u%0d", i), 32'(gnt_o[i]), 0);
      check($sformatf("async_rst_busy_u%0d", i), 32'(busy_o[i]), 0);
      check($sformatf("async_rst_cnt_u%0d", i), cnt0(i) + cnt1(i), 0);
    end
    ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1;
    tick();
    ARESETn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("release_gnt_u%0d", i), 32'(gnt_o[i]), 1);

    // Contention with ready held high for eight handshakes.
    ARREADY = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rr_gnt_k%0d", k), 32'(gnt_o[0]), (k % 2 == 0) ? 2 : 1);
      check($sformatf("fix_gnt_k%0d", k), 32'(gnt_o[1]), 1);
      check($sformatf("sat_cnt0_k%0d", k), cnt0(2), (k + 1 < 3) ? k + 1 : 3);
    end
    check("rr_cnt0", cnt0(0), 4);
    check("rr_cnt1", cnt1(0), 4);
    check("fix_cnt0", cnt0(1), 8);
    check("fix_cnt1", cnt1(1), 0);
    check("sat_cnt1", cnt1(2), 0);
    ARREADY = 1'b0; ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ar_arbiter.md
Name: ar_arbiter

Overview:
- Read-address channel arbiter for the two-master AXI interconnect.
- Selects which master (M0 or M1) owns the AR channel and drives the one-hot `gnt` consumed directly by the AR multiplexer.
- Holds each grant until the AR handshake completes, then rotates priority round-robin.
- Routes ARREADY back to the granted master only, and keeps per-master accepted-request counters for debug.

Parameters:
- CNT_W, 16, width of each per-master handshake counter (saturating).
- RR_EN, 1, 1 = round-robin priority; 0 = fixed priority, M0 always wins.

Ports:
- ACLK  input  1  system clock, all state updates on rising edge
- ARESETn  input  1  asynchronous active-low reset
- ARVALID_M0  input  1  read-address valid from master 0
- ARVALID_M1  input  1  read-address valid from master 1
- ARREADY  input  1  read-address ready from the slave-side path (after the AR mux/decoder)
- gnt  output  2  registered one-hot grant to the AR mux: 2'b01 = M0, 2'b10 = M1, 2'b00 = none
- ARREADY_M0  output  1  ARREADY returned to master 0
- ARREADY_M1  output  1  ARREADY returned to master 1
- busy  output  1  high while any grant is held
- hs_cnt_m0  output  CNT_W  accepted AR handshakes from M0
- hs_cnt_m1  output  CNT_W  accepted AR handshakes from M1

Behaviour:
- Reset (ARESETn low, asynchronous): state=IDLE, gnt=2'b00, busy=0, priority pointer=M0, both counters=0.
  - Reset asserted mid-grant drops gnt to 2'b00 immediately, with no wait for ACLK.
  - Reset release takes effect at the first ACLK rising edge after ARESETn goes high.
- States: IDLE, GNT_M0, GNT_M1. `gnt` is decoded from state and is always one-hot or zero, never 2'b11.
- `busy` = (state != IDLE).
- IDLE:
  - If any ARVALID is high, move at the next edge to the GNT state of the winner.
  - One-cycle arbitration latency: valid seen in cycle N, gnt asserted in cycle N+1.
- Winner selection:
  - Only one requester: it wins.
  - Both requesting, RR_EN=1: the master the pointer names wins.
  - Both requesting, RR_EN=0: M0 wins.
- GNT_Mx, no handshake: while the handshake (ARVALID_Mx & ARREADY) has not occurred, hold state and gnt unchanged. The arbiter never preempts a granted master.
- GNT_Mx, handshake cycle:
  - Increment hs_cnt_mx, saturating at all-ones with no wrap.
  - Set the pointer to the other master.
  - Next state is chosen by re-arbitrating in the same cycle with the updated pointer:
    - Other master valid: grant it next cycle (back-to-back handoff, no IDLE bubble).
    - Else same master still valid: re-grant it.
    - Else: go to IDLE.
- Simultaneous requests in IDLE: resolved by the pointer. The pointer changes only on a completed handshake.
- ARREADY routing (combinational):
  - ARREADY_M0 = ARREADY & gnt[0]; ARREADY_M1 = ARREADY & gnt[1].
  - When gnt=00, neither master sees ready.
- ARREADY high while gnt=00: ignored, no state change, no count.
- Granted master's ARVALID low (protocol violation): grant is held. No timeout is required.

Decomposition:
- Shared AXI package:
  - `ar_gnt_e` enum: GNT_NONE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10, consumed by both ar_arbiter and the AR mux.
  - Master-count constant NUM_MASTERS=2.
  - Existing AXI width macros stay as-is.
- Sub-module `sat_counter` (parameter WIDTH, inputs inc/clr, async active-low reset) instantiated twice for hs_cnt_m0/m1.
- FSM and pointer live in ar_arbiter.

Test Plan:
- Reset: assert ARESETn=0 mid-GNT_M1 -> gnt=2'b00, busy=0, counters=0 without waiting for ACLK.
  - After release with both valids high -> gnt=2'b01 one cycle later (pointer=M0).
- Single master: ARVALID_M1=1, ARREADY=1 on the third granted cycle -> gnt=2'b10 from cycle 1 through the handshake cycle.
  - ARREADY_M1 high only while granted; hs_cnt_m1=1; return to IDLE.
- Round-robin contention (RR_EN=1): both valids held high, ARREADY=1 continuously -> gnt alternates 01,10,01,10 every cycle.
  - After 8 handshakes, hs_cnt_m0=4 and hs_cnt_m1=4.
- Fixed priority (RR_EN=0): both valids held high, ARREADY=1 -> gnt stays 2'b01; hs_cnt_m1 stays 0.
- Isolation: gnt=2'b01 with ARREADY pulsed -> ARREADY_M1 stays 0.
  - ARREADY high while gnt=2'b00 -> no state change, no count increment.
- Saturation (CNT_W=2): 5 M0 handshakes -> hs_cnt_m0=3 after the third, stays 3.
